// File: rtl/operand_batch_sched_if.sv
// Operand-batch scheduler bus: requester lanes, bfm operand port and batch status.
// The slave modport is the scheduler side; master drives requests and op_ready.
interface operand_batch_sched_if #(
    parameter int unsigned NUM        = 100,
    parameter int unsigned ITEM_WIDTH = 8,
    parameter int unsigned N_REQ      = 2
);
    localparam int unsigned ID_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int unsigned CNT_W = $clog2(NUM + 1);

    logic [N_REQ-1:0]            req_valid_i;
    logic [N_REQ-1:0]            req_last_i;
    logic [N_REQ*ITEM_WIDTH-1:0] req_a_i;
    logic [N_REQ*ITEM_WIDTH-1:0] req_b_i;
    logic [N_REQ-1:0]            req_ready_o;
    logic                        op_valid_o;
    logic                        op_ready_i;
    logic [ITEM_WIDTH-1:0]       A_s;
    logic [ITEM_WIDTH-1:0]       B_s;
    logic [N_REQ-1:0]            grant_o;
    logic                        busy_o;
    logic                        done_o;
    logic [ID_W-1:0]             done_id_o;
    logic [CNT_W-1:0]            batch_cnt_o;
    logic                        xmit_en_o;

    modport master (
        output req_valid_i, req_last_i, req_a_i, req_b_i, op_ready_i,
        input  req_ready_o, op_valid_o, A_s, B_s, grant_o, busy_o,
               done_o, done_id_o, batch_cnt_o, xmit_en_o
    );

    modport slave (
        input  req_valid_i, req_last_i, req_a_i, req_b_i, op_ready_i,
        output req_ready_o, op_valid_o, A_s, B_s, grant_o, busy_o,
               done_o, done_id_o, batch_cnt_o, xmit_en_o
    );
endinterface

// File: rtl/operand_batch_sched.sv
// Round-robin, non-preemptive batch scheduler sharing one A/B operand port
// between N_REQ requesters through a one-deep output register.
module operand_batch_sched #(
    parameter int unsigned NUM        = 100,
    parameter int unsigned ITEM_WIDTH = 8,
    parameter int unsigned N_REQ      = 2
) (
    input logic                 clk_i,
    input logic                 reset_i,
    operand_batch_sched_if.slave bus
);
    localparam int unsigned ID_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int unsigned CNT_W = $clog2(NUM + 1);

    typedef enum logic [1:0] {IDLE, STREAM, DRAIN, DONE} state_t;

    state_t                state, state_nxt;
    logic [ID_W-1:0]       owner, owner_nxt;
    logic [ID_W-1:0]       rr_ptr, rr_ptr_nxt;
    logic [CNT_W-1:0]      cnt, cnt_nxt;
    logic [N_REQ-1:0]      grant_nxt;
    logic                  op_valid_nxt;
    logic [ITEM_WIDTH-1:0] a_nxt, b_nxt;
    logic                  busy_nxt;
    logic                  done_nxt;
    logic [ID_W-1:0]       done_id_nxt;
    logic [CNT_W-1:0]      batch_cnt_nxt;
    logic                  xmit_nxt;
    logic [N_REQ-1:0]      req_ready;
    logic                  room;
    logic [ID_W-1:0]       pick;
    logic                  pick_ok;
    logic [ITEM_WIDTH-1:0] a_arr [N_REQ];
    logic [ITEM_WIDTH-1:0] b_arr [N_REQ];

    // Unpack requester lanes so the owner can be selected by index.
    always_comb begin
        for (int unsigned r = 0; r < N_REQ; r++) begin
            a_arr[r] = bus.req_a_i[r*ITEM_WIDTH +: ITEM_WIDTH];
            b_arr[r] = bus.req_b_i[r*ITEM_WIDTH +: ITEM_WIDTH];
        end
    end

    // First valid requester at or after the round-robin pointer, wrapping.
    always_comb begin
        logic [ID_W-1:0] idx;
        idx     = '0;
        pick    = '0;
        pick_ok = 1'b0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            idx = ID_W'((32'(rr_ptr) + i) % N_REQ);
            if (!pick_ok && bus.req_valid_i[idx]) begin
                pick_ok = 1'b1;
                pick    = idx;
            end
        end
    end

    always_comb begin
        state_nxt     = state;
        owner_nxt     = owner;
        rr_ptr_nxt    = rr_ptr;
        cnt_nxt       = cnt;
        grant_nxt     = bus.grant_o;
        op_valid_nxt  = bus.op_valid_o;
        a_nxt         = bus.A_s;
        b_nxt         = bus.B_s;
        done_nxt      = 1'b0;
        done_id_nxt   = bus.done_id_o;
        batch_cnt_nxt = bus.batch_cnt_o;
        xmit_nxt      = bus.xmit_en_o;
        req_ready     = '0;
        room          = !bus.op_valid_o || bus.op_ready_i;

        // A consumed pair empties the register unless a new accept refills it below.
        if (bus.op_valid_o && bus.op_ready_i) begin
            op_valid_nxt = 1'b0;
        end

        case (state)
            IDLE: begin
                if (pick_ok) begin
                    state_nxt = STREAM;
                    owner_nxt = pick;
                    grant_nxt = N_REQ'(1) << pick;
                end
            end
            STREAM: begin
                req_ready[owner] = room;
                if (bus.req_valid_i[owner] && room) begin
                    op_valid_nxt = 1'b1;
                    a_nxt        = a_arr[owner];
                    b_nxt        = b_arr[owner];
                    cnt_nxt      = cnt + CNT_W'(1);
                    if (bus.req_last_i[owner] || (cnt == CNT_W'(NUM - 1))) begin
                        state_nxt = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (room) begin
                    state_nxt     = DONE;
                    done_nxt      = 1'b1;
                    done_id_nxt   = owner;
                    batch_cnt_nxt = cnt;
                    xmit_nxt      = !bus.xmit_en_o;
                end
            end
            DONE: begin
                state_nxt  = IDLE;
                rr_ptr_nxt = (owner == ID_W'(N_REQ - 1)) ? '0 : owner + ID_W'(1);
                cnt_nxt    = '0;
                grant_nxt  = '0;
            end
            default: state_nxt = IDLE;
        endcase

        busy_nxt = (state_nxt != IDLE);
    end

    assign bus.req_ready_o = req_ready;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state           <= IDLE;
            owner           <= '0;
            rr_ptr          <= '0;
            cnt             <= '0;
            bus.grant_o     <= '0;
            bus.op_valid_o  <= 1'b0;
            bus.A_s         <= '0;
            bus.B_s         <= '0;
            bus.busy_o      <= 1'b0;
            bus.done_o      <= 1'b0;
            bus.done_id_o   <= '0;
            bus.batch_cnt_o <= '0;
            bus.xmit_en_o   <= 1'b0;
        end else begin
            state           <= state_nxt;
            owner           <= owner_nxt;
            rr_ptr          <= rr_ptr_nxt;
            cnt             <= cnt_nxt;
            bus.grant_o     <= grant_nxt;
            bus.op_valid_o  <= op_valid_nxt;
            bus.A_s         <= a_nxt;
            bus.B_s         <= b_nxt;
            bus.busy_o      <= busy_nxt;
            bus.done_o      <= done_nxt;
            bus.done_id_o   <= done_id_nxt;
            bus.batch_cnt_o <= batch_cnt_nxt;
            bus.xmit_en_o   <= xmit_nxt;
        end
    end
endmodule

// File: tb/tb_operand_batch_sched.sv
// Randomized bench for operand_batch_sched: requester queues feed the DUT while a
// queue-level round-robin model predicts the operand stream and the done reports.
module tb_operand_batch_sched;
    localparam int unsigned NUM   = 100;
    localparam int unsigned W     = 8;
    localparam int unsigned N     = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    operand_batch_sched_if #(.NUM(NUM), .ITEM_WIDTH(W), .N_REQ(N)) bus ();

    operand_batch_sched #(.NUM(NUM), .ITEM_WIDTH(W), .N_REQ(N)) dut (
        .clk_i   (clk),
        .reset_i (rst),
        .bus     (bus)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Pending pairs per requester: {last, a, b}.
    logic [16:0] srcq [N][$];
    logic [15:0] exp_pairs [$];
    int          exp_done [$];     // id*256 + count
    int          m_ptr;
    logic        m_xmit;
    int          g_cycles;

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic drive_idle();
        bus.req_valid_i = '0;
        bus.req_last_i  = '0;
        bus.req_a_i     = '0;
        bus.req_b_i     = '0;
        bus.op_ready_i  = 1'b0;
    endtask

    task automatic check_zero(input string pfx);
        chk_eq({pfx, "_op_valid"},  32'(bus.op_valid_o), 0);
        chk_eq({pfx, "_a"},         32'(bus.A_s), 0);
        chk_eq({pfx, "_b"},         32'(bus.B_s), 0);
        chk_eq({pfx, "_grant"},     32'(bus.grant_o), 0);
        chk_eq({pfx, "_busy"},      32'(bus.busy_o), 0);
        chk_eq({pfx, "_done"},      32'(bus.done_o), 0);
        chk_eq({pfx, "_done_id"},   32'(bus.done_id_o), 0);
        chk_eq({pfx, "_batch_cnt"}, 32'(bus.batch_cnt_o), 0);
        chk_eq({pfx, "_xmit"},      32'(bus.xmit_en_o), 0);
        chk_eq({pfx, "_ready"},     32'(bus.req_ready_o), 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive_idle();
        repeat (2) @(negedge clk);
        check_zero("reset");
        rst    = 1'b0;
        m_ptr  = 0;
        m_xmit = 1'b0;
    endtask

    task automatic gen_batch(input int r, input int len);
        for (int i = 0; i < len; i++) begin
            srcq[r].push_back({(i == len - 1), 8'($urandom), 8'($urandom)});
        end
    endtask

    // Serve requesters with pending pairs in round-robin order, one batch at a time.
    task automatic build_model();
        logic [16:0] q [N][$];
        logic [16:0] item;
        int          pick;
        int          cnt;
        for (int r = 0; r < N; r++) q[r] = srcq[r];
        forever begin
            pick = -1;
            for (int i = 0; i < N; i++) begin
                if (pick < 0 && q[(m_ptr + i) % N].size() > 0) pick = (m_ptr + i) % N;
            end
            if (pick < 0) break;
            cnt = 0;
            do begin
                item = q[pick].pop_front();
                exp_pairs.push_back(item[15:0]);
                cnt++;
            end while (!item[16] && cnt < NUM && q[pick].size() > 0);
            exp_done.push_back(pick * 256 + cnt);
            m_ptr = (pick + 1) % N;
        end
    endtask

    // rdy_pct < 0 selects a fixed 3-cycle op_ready stall at cycles 4..6.
    task automatic run_phase(input int max_cyc, input int rdy_pct, input int gap_pct, input int abort_at);
        int           cyc = 0;
        int           acc_total = 0;
        int           bcnt [N];
        bit           mid [N];
        bit           fin = 0;
        logic         prev_stall = 1'b0;
        logic [7:0]   prev_a = '0, prev_b = '0;
        logic [N-1:0] vv, vl;
        logic [N*W-1:0] va, vb;
        logic [16:0]  item;
        int           e;
        for (int r = 0; r < N; r++) begin bcnt[r] = 0; mid[r] = 0; end
        g_cycles = 0;
        while (!fin && cyc < max_cyc) begin
            @(negedge clk);
            if (bus.grant_o != '0) g_cycles++;
            if (prev_stall) begin
                chk_eq("stall_a", 32'(bus.A_s), 32'(prev_a));
                chk_eq("stall_b", 32'(bus.B_s), 32'(prev_b));
                chk_eq("stall_valid", 32'(bus.op_valid_o), 1);
            end
            if (bus.done_o) begin
                if (exp_done.size() == 0) chk_eq("done_unexpected", 1, 0);
                else begin
                    e = exp_done.pop_front();
                    m_xmit = !m_xmit;
                    chk_eq("done_id", 32'(bus.done_id_o), 32'(e / 256));
                    chk_eq("batch_cnt", 32'(bus.batch_cnt_o), 32'(e % 256));
                    chk_eq("xmit_en", 32'(bus.xmit_en_o), 32'(m_xmit));
                    chk_eq("done_grant", 32'(bus.grant_o), 32'(1) << (e / 256));
                end
            end
            fin = !bus.busy_o && !bus.op_valid_o && exp_pairs.size() == 0 && exp_done.size() == 0;
            for (int r = 0; r < N; r++) if (srcq[r].size() > 0) fin = 0;
            if (!fin) begin
                if (rdy_pct < 0) bus.op_ready_i = !(cyc >= 4 && cyc < 7);
                else             bus.op_ready_i = ($urandom_range(99) < rdy_pct);
                vv = '0; vl = '0; va = '0; vb = '0;
                for (int r = 0; r < N; r++) begin
                    if (srcq[r].size() > 0 && !(mid[r] && $urandom_range(99) < gap_pct)) begin
                        item = srcq[r][0];
                        vv |= N'(1) << r;
                        vl |= N'(item[16]) << r;
                        va |= (N*W)'(item[15:8]) << (r * W);
                        vb |= (N*W)'(item[7:0]) << (r * W);
                    end else begin
                        vl |= N'($urandom & 1) << r;
                        va |= (N*W)'(8'($urandom)) << (r * W);
                        vb |= (N*W)'(8'($urandom)) << (r * W);
                    end
                end
                bus.req_valid_i = vv;
                bus.req_last_i  = vl;
                bus.req_a_i     = va;
                bus.req_b_i     = vb;
                #1;
                if (bus.op_valid_o && bus.op_ready_i) begin
                    if (exp_pairs.size() == 0) chk_eq("pair_unexpected", 1, 0);
                    else chk_eq("pair", 32'({bus.A_s, bus.B_s}), 32'(exp_pairs.pop_front()));
                end
                if (bus.op_valid_o && !bus.op_ready_i) chk_eq("ready_in_stall", 32'(bus.req_ready_o), 0);
                prev_stall = bus.op_valid_o && !bus.op_ready_i;
                prev_a = bus.A_s;
                prev_b = bus.B_s;
                for (int r = 0; r < N; r++) begin
                    if (vv[r] && bus.req_ready_o[r]) begin
                        item = srcq[r].pop_front();
                        acc_total++;
                        bcnt[r]++;
                        if (item[16] || bcnt[r] == NUM) begin mid[r] = 0; bcnt[r] = 0; end
                        else mid[r] = 1;
                    end
                end
                if (abort_at > 0 && acc_total == abort_at) begin
                    @(posedge clk);
                    #2;
                    rst = 1'b1;
                    drive_idle();
                    #1;
                    check_zero("abort");
                    for (int r = 0; r < N; r++) srcq[r].delete();
                    exp_pairs.delete();
                    exp_done.delete();
                    m_ptr  = 0;
                    m_xmit = 1'b0;
                    repeat (2) @(negedge clk);
                    check_zero("abort_hold");
                    rst = 1'b0;
                    fin = 1;
                end
            end
            cyc++;
        end
        if (!fin) chk_eq("phase_timeout", 32'(cyc), 32'(max_cyc + 1));
        drive_idle();
    endtask

    initial begin
        rst = 1'b1;
        drive_idle();
        do_reset();

        // Single 5-pair batch from requester 0 at full throughput.
        gen_batch(0, 5);
        build_model();
        run_phase(200, 100, 0, 0);
        chk_eq("p1_xmit_final", 32'(bus.xmit_en_o), 1);

        // Both requesters waiting right after reset: 0 served before 1.
        do_reset();
        gen_batch(0, 4);
        gen_batch(1, 3);
        build_model();
        run_phase(200, 100, 0, 0);
        chk_eq("p2_xmit_final", 32'(bus.xmit_en_o), 0);

        // 150 pairs without early last: forced split at NUM.
        gen_batch(1, 150);
        build_model();
        run_phase(1000, 100, 0, 0);

        // Fixed 3-cycle output stall mid-batch.
        gen_batch(0, 10);
        build_model();
        run_phase(200, -1, 0, 0);

        // Random batches, random backpressure and mid-batch valid gaps.
        for (int r = 0; r < N; r++) begin
            for (int b = 0; b < 3; b++) gen_batch(r, 1 + $urandom_range(11));
        end
        build_model();
        run_phase(3000, 60, 20, 0);

        // Reset after 40 accepted pairs, then a fresh batch counts from zero.
        for (int i = 0; i < 60; i++) begin
            srcq[0].push_back({(i == 59), 8'($urandom), 8'($urandom)});
            exp_pairs.push_back(srcq[0][i][15:0]);
        end
        run_phase(500, 100, 0, 40);
        gen_batch(1, 3);
        build_model();
        run_phase(200, 100, 0, 0);
        chk_eq("p5_batch_cnt_final", 32'(bus.batch_cnt_o), 3);

        // Single-pair batch: grant spans exactly STREAM, DRAIN, DONE.
        gen_batch(0, 1);
        build_model();
        run_phase(200, 100, 0, 0);
        chk_eq("p6_grant_cycles", 32'(g_cycles), 3);
        chk_eq("p6_batch_cnt", 32'(bus.batch_cnt_o), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
